pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the fetch stage; next generation of the plain PC register.

---
 rtl/pc_sequencer.sv | 47 ++++
 tb/tb_pc_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC (clk, rst, stall, redirect, redirect_pc, halt, resume -> PC, npc, pc_valid, misalign, state) with boot cycle, redirect > halt > stall > increment
module pc_sequencer #(
  parameter int W = 32,
  parameter int STEP = 4,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  input  logic         halt,
  input  logic         resume,
  output logic [W-1:0] PC,
  output logic [W-1:0] npc,
  output logic         pc_valid,
  output logic         misalign,
  output logic [1:0]   state
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam logic [W-1:0] MASK = W'(STEP - 1);
  state_t st, st_n;
  logic [W-1:0] pc_n;
  logic mis_n, run, act;
  always_comb begin
    run = st == RUN;
    act = redirect && (run || st == HALT);
    pc_n = act ? redirect_pc & ~MASK : (run && !halt && !stall) ? PC + W'(STEP) : PC;
    st_n = run ? (halt ? HALT : RUN) : st == HALT ? (resume ? RUN : HALT) : RUN;
    mis_n = misalign | (act && |(redirect_pc & MASK));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      PC <= RESET_VEC;
      st <= BOOT;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      PC <= pc_n;
      st <= st_n;
      pc_valid <= st_n == RUN;
      misalign <= mis_n;
    end
  end
  assign npc = PC + W'(STEP);
  assign state = st;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with directed scenarios and randomized traffic
module tb_pc_sequencer;
  logic clk = 0, rst = 0, stall = 0, redirect = 0, halt = 0, resume = 0;
  logic [31:0] redirect_pc = 0, pc, npc;
  logic pc_valid, misalign;
  logic [1:0] state;
  typedef struct {logic [31:0] pc; logic [31:0] npc; logic valid; logic mis; logic [1:0] st;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  logic [31:0] m_pc = 0;
  logic m_valid = 0, m_mis = 0;
  logic [1:0] m_st = 0;
  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .resume(resume), .PC(pc), .npc(npc), .pc_valid(pc_valid),
    .misalign(misalign), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    check("pc", pc, e.pc);
    check("npc", npc, e.npc);
    check("pc_valid", 32'(pc_valid), 32'(e.valid));
    check("misalign", 32'(misalign), 32'(e.mis));
    check("state", 32'(state), 32'(e.st));
  end
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rp, input bit h, input bit rs);
    exp_t e;
    rst = r; stall = s; redirect = rd; redirect_pc = rp; halt = h; resume = rs;
    if (r) begin
      m_pc = 0; m_valid = 0; m_mis = 0; m_st = 0;
    end else if (m_st == 1) begin
      if (rd) begin
        m_pc = {rp[31:2], 2'b00};
        if (rp[1:0] != 0) m_mis = 1;
        if (h) begin m_st = 2; m_valid = 0; end
      end else if (h) begin
        m_st = 2; m_valid = 0;
      end else if (!s) m_pc = m_pc + 4;
    end else if (m_st == 2) begin
      if (rd) begin
        m_pc = {rp[31:2], 2'b00};
        if (rp[1:0] != 0) m_mis = 1;
      end
      if (rs) begin m_st = 1; m_valid = 1; end
    end else begin
      m_st = 1; m_valid = 1;
    end
    e.pc = m_pc; e.npc = m_pc + 4; e.valid = m_valid; e.mis = m_mis; e.st = m_st;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h8, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h100, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h102, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h80, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      int sel;
      sel = $urandom_range(0, 3);
      rp = sel == 0 ? $urandom : sel == 1 ? {$urandom_range(0, 1023), 2'b00} : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 12, rp,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
